// File: rtl/parking_gate_ctrl_pkg.sv
// parking_pkg: shared constants, FSM state type and slot-allocation helper
// for the parking gate controller.
//   TIMER_W         width of the free-running time base
//   DEF_NUM_SLOTS   default slot count (one-hot car_sel/occupied width)
//   SLOT1..SLOT3    one-hot slot codes
//   gate_state_t    controller FSM states
//   lowest_free_idx index of the lowest clear bit in an occupancy vector
package parking_pkg;

    localparam int TIMER_W       = 10;
    localparam int DEF_NUM_SLOTS = 3;
    localparam int MAX_SLOTS     = 32;

    localparam logic [2:0] SLOT1 = 3'b001;
    localparam logic [2:0] SLOT2 = 3'b010;
    localparam logic [2:0] SLOT3 = 3'b100;

    typedef enum logic {IDLE, GATE} gate_state_t;

    // Callers zero-extend a narrower occupancy vector, so a full vector
    // yields its own width as the index and shifting by it gives zero.
    function automatic int lowest_free_idx(input logic [MAX_SLOTS-1:0] occ);
        int idx;
        idx = MAX_SLOTS;
        for (int i = MAX_SLOTS - 1; i >= 0; i--)
            if (!occ[i]) idx = i;
        return idx;
    endfunction

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// parking_gate_ctrl_if: request/ack and datapath-strobe bundle of the gate
// controller.
//   master: gate buttons / requester side (drives entry_req, exit_req, exit_slot)
//   slave : controller side (drives acks, reject, strobes, car_sel, occupied,
//           full, gate_open, timer_count)
interface parking_gate_ctrl_if #(
    parameter int NUM_SLOTS = parking_pkg::DEF_NUM_SLOTS
);
    import parking_pkg::*;

    logic                 entry_req;
    logic                 exit_req;
    logic [NUM_SLOTS-1:0] exit_slot;
    logic                 entry_ack;
    logic                 exit_ack;
    logic                 reject;
    logic                 car_enter;
    logic                 car_exit;
    logic [NUM_SLOTS-1:0] car_sel;
    logic [NUM_SLOTS-1:0] occupied;
    logic                 full;
    logic                 gate_open;
    logic [TIMER_W-1:0]   timer_count;

    modport master (
        output entry_req, exit_req, exit_slot,
        input  entry_ack, exit_ack, reject, car_enter, car_exit, car_sel,
               occupied, full, gate_open, timer_count
    );

    modport slave (
        input  entry_req, exit_req, exit_slot,
        output entry_ack, exit_ack, reject, car_enter, car_exit, car_sel,
               occupied, full, gate_open, timer_count
    );

endinterface

// File: rtl/parking_gate_ctrl_tick_timer.sv
// parking_tick_timer: prescaler dividing clk by TICK_DIV feeding a 10-bit
// wrapping time base.
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   timer_count free-running count, +1 every TICK_DIV cycles, wraps to 0
module parking_tick_timer
    import parking_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic               clk,
    input  logic               reset,
    output logic [TIMER_W-1:0] timer_count
);

    localparam int PW = $clog2(TICK_DIV);

    logic [PW-1:0]      r_pre;
    logic [TIMER_W-1:0] r_count;
    logic               w_wrap;

    assign w_wrap      = r_pre == PW'(TICK_DIV - 1);
    assign timer_count = r_count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pre   <= '0;
            r_count <= '0;
        end else begin
            r_pre   <= w_wrap ? '0 : r_pre + 1'b1;
            r_count <= r_count + TIMER_W'(w_wrap);
        end
    end

endmodule

// File: rtl/parking_gate_ctrl.sv
// parking_gate_ctrl: arbitrates gate entry/exit requests, allocates the
// lowest free slot, strobes the cost datapath and sequences the barrier.
//   clk   system clock, rising edge
//   reset asynchronous active-low reset
//   bus   slave side of parking_gate_ctrl_if (requests in; acks, reject,
//         car_enter/car_exit, one-hot car_sel, occupied, full, gate_open,
//         timer_count out; all outputs registered)
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int NUM_SLOTS   = DEF_NUM_SLOTS,
    parameter int TICK_DIV    = 50000000,
    parameter int GATE_CYCLES = 100
) (
    input  logic                clk,
    input  logic                reset,
    parking_gate_ctrl_if.slave  bus
);

    localparam int CW = $clog2(GATE_CYCLES + 1);

    gate_state_t          r_state;
    logic                 r_entry_ack;
    logic                 r_exit_ack;
    logic                 r_reject;
    logic                 r_car_enter;
    logic                 r_car_exit;
    logic [NUM_SLOTS-1:0] r_car_sel;
    logic [NUM_SLOTS-1:0] r_occ;
    logic                 r_full;
    logic                 r_gate;
    logic [CW-1:0]        r_cnt;
    logic                 r_entry_first;
    logic [TIMER_W-1:0]   w_timer;

    logic                 w_sample;
    logic                 w_pick_exit;
    logic                 w_do_entry;
    logic                 w_do_exit;
    logic                 w_exit_ok;
    logic                 w_accept;
    logic [NUM_SLOTS-1:0] w_free;
    logic [NUM_SLOTS-1:0] w_sel;
    logic [NUM_SLOTS-1:0] w_occ_next;

    parking_tick_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk         (clk),
        .reset       (reset),
        .timer_count (w_timer)
    );

    always_comb begin
        // A request still high right after its ack is the same request,
        // so sampling waits one cycle after any ack.
        w_sample    = r_state == IDLE && !r_entry_ack && !r_exit_ack;
        // When full an entry can only be refused, so a pending exit goes first.
        w_pick_exit = bus.exit_req && (!bus.entry_req || r_full || !r_entry_first);
        w_do_exit   = w_sample && w_pick_exit;
        w_do_entry  = w_sample && bus.entry_req && !w_pick_exit;
        w_exit_ok   = bus.exit_slot != '0
                      && (bus.exit_slot & (bus.exit_slot - 1'b1)) == '0
                      && (bus.exit_slot & r_occ) != '0;
        w_free      = NUM_SLOTS'(1) << lowest_free_idx(MAX_SLOTS'(r_occ));
        w_accept    = (w_do_exit && w_exit_ok) || (w_do_entry && !r_full);
        w_sel       = w_do_exit ? bus.exit_slot : w_free;
        w_occ_next  = !w_accept ? r_occ
                    : w_do_exit ? r_occ & ~bus.exit_slot
                    : r_occ | w_free;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_entry_ack   <= 1'b0;
            r_exit_ack    <= 1'b0;
            r_reject      <= 1'b0;
            r_car_enter   <= 1'b0;
            r_car_exit    <= 1'b0;
            r_car_sel     <= '0;
            r_occ         <= '0;
            r_full        <= 1'b0;
            r_gate        <= 1'b0;
            r_cnt         <= '0;
            r_entry_first <= 1'b1;
        end else begin
            r_entry_ack <= w_do_entry;
            r_exit_ack  <= w_do_exit;
            r_reject    <= (w_do_entry || w_do_exit) && !w_accept;
            r_car_enter <= w_do_entry && w_accept;
            r_car_exit  <= w_do_exit && w_accept;
            r_car_sel   <= w_accept ? w_sel : '0;
            r_occ       <= w_occ_next;
            r_full      <= &w_occ_next;
            if (r_state == IDLE) begin
                if (w_accept) begin
                    r_state       <= GATE;
                    r_gate        <= 1'b1;
                    r_cnt         <= CW'(GATE_CYCLES - 1);
                    r_entry_first <= ~r_entry_first;
                end
            end else if (r_cnt == '0) begin
                r_state <= IDLE;
                r_gate  <= 1'b0;
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign bus.entry_ack   = r_entry_ack;
    assign bus.exit_ack    = r_exit_ack;
    assign bus.reject      = r_reject;
    assign bus.car_enter   = r_car_enter;
    assign bus.car_exit    = r_car_exit;
    assign bus.car_sel     = r_car_sel;
    assign bus.occupied    = r_occ;
    assign bus.full        = r_full;
    assign bus.gate_open   = r_gate;
    assign bus.timer_count = w_timer;

endmodule

// File: doc/parking_gate_ctrl.md
Name: parking_gate_ctrl

Overview:
Front-end controller for the 3-slot parking datapath. It arbitrates entry and exit requests from the gate buttons and allocates the lowest free slot on entry. It issues the one-cycle car_enter/car_exit strobes with a one-hot car_sel to the cost datapath, and sequences the barrier gate. It also owns the free-running 10-bit timer_count that the datapath uses for enter-time and cost arithmetic.

Parameters:
NUM_SLOTS, 3, number of slots; car_sel/occupied width; one-hot encoding
TICK_DIV, 50000000, clk cycles per timer_count increment (>=2)
GATE_CYCLES, 100, cycles gate_open is held per accepted car (>=1)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (reset==0 resets)
entry_req  in  1  level; held by requester until entry_ack
exit_req  in  1  level; held by requester until exit_ack
exit_slot  in  NUM_SLOTS  one-hot slot leaving; valid while exit_req=1
entry_ack  out  1  one-cycle pulse; entry request consumed (accepted or rejected)
exit_ack  out  1  one-cycle pulse; exit request consumed (accepted or rejected)
reject  out  1  one-cycle pulse with an ack when the request is refused
car_enter  out  1  one-cycle strobe to datapath
car_exit  out  1  one-cycle strobe to datapath
car_sel  out  NUM_SLOTS  one-hot slot; valid with car_enter/car_exit, else 0
occupied  out  NUM_SLOTS  per-slot occupancy
full  out  1  occupied all ones
gate_open  out  1  barrier open
timer_count  out  10  free-running time base, wraps 1023->0

Behaviour:
- Reset (reset==0, async): all outputs 0; prescaler 0; FSM IDLE; priority bit = entry-first.
- All outputs are registered.
- Timer: prescaler counts 0..TICK_DIV-1. On wrap, timer_count +1 mod 1024. Runs in every FSM state.
- FSM states: IDLE, GATE.
- Request sampling: IDLE samples requests only when neither ack was high in the previous cycle. This stops a held request from being re-served.
- In IDLE with a candidate request at edge N, the following is registered at edge N and visible in cycle N+1 for exactly one cycle:
  - Entry, not full: entry_ack=1, car_enter=1, car_sel = lowest-index free slot, occupied bit set. Go to GATE.
  - Entry, full: entry_ack=1, reject=1, no car strobe. Stay IDLE.
  - Exit with exit_slot one-hot and that slot occupied: exit_ack=1, car_exit=1, car_sel=exit_slot, occupied bit cleared. Go to GATE.
  - Exit with exit_slot not one-hot or slot free: exit_ack=1, reject=1. Stay IDLE.
- Arbitration when both requests are pending:
  - If full, exit wins.
  - Otherwise the priority bit decides, and it toggles after each accepted (non-rejected) grant.
  - The loser stays pending and is served on a later IDLE cycle.
- GATE: gate_open=1 for exactly GATE_CYCLES cycles, starting cycle N+1, via a down-counter. Then gate_open=0 and FSM returns to IDLE. Requests are not sampled in GATE.
- full = &occupied, updated in the same cycle as occupied.
- Reset mid-GATE: gate closes immediately, occupancy cleared, no pending state retained.
- Request dropped before ack: no action; no ack generated.

Decomposition:
- Package parking_pkg holds:
  - TIMER_W=10
  - NUM_SLOTS default
  - slot one-hot constants SLOT1=3'b001, SLOT2=3'b010, SLOT3=3'b100
  - FSM state enum {IDLE, GATE}
  - lowest-free-slot priority function
- Sub-module parking_tick_timer: prescaler plus 10-bit wrapping counter (clk, reset, timer_count).

Test Plan:
Bench uses TICK_DIV=4, GATE_CYCLES=3.
1. Reset release, idle 8 cycles -> timer_count increments every 4 cycles (0,1,2); all other outputs 0.
2. entry_req with occupied=000 -> next cycle entry_ack=car_enter=1, car_sel=001, occupied=001; gate_open=1 for exactly 3 cycles; a second entry_req held throughout is not served until gate_open falls, then car_sel=010.
3. Fill three slots, then entry_req -> entry_ack=reject=1, car_enter=0, gate_open stays 0, full=1.
4. With occupied=111, assert entry_req and exit_req (exit_slot=010) together -> exit served first (car_exit=1, car_sel=010, occupied=101); after the gate cycle, entry gets car_sel=010.
5. exit_req with exit_slot=100 while occupied=001 -> reject=1, occupied unchanged; exit_slot=011 -> reject=1.
6. Drive reset=0 during cycle 2 of the GATE state -> gate_open, occupied and timer_count go 0 immediately without waiting for clk; after release, entry gets car_sel=001.
